// File: rtl/bcd_digit_serializer.sv
// Serializes a packed BCD word into one digit per ready/valid beat, MSD first,
// flagging leading zeros, out-of-range digits and the final beat.
module bcd_digit_serializer #(
  parameter int unsigned DIGITS_NUM = 6,
  localparam int unsigned IW = (DIGITS_NUM > 1) ? $clog2(DIGITS_NUM) : 1,
  localparam int unsigned DW = 4 * DIGITS_NUM
) (
  input  logic          clk_in,
  input  logic          reset_in,
  input  logic          start_in,
  input  logic [DW-1:0] digits_in,
  output logic          busy_out,
  output logic          valid_out,
  input  logic          ready_in,
  output logic [3:0]    digit_out,
  output logic [IW-1:0] index_out,
  output logic          blank_out,
  output logic          bad_out,
  output logic          last_out,
  output logic          done_out
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_SEND = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  logic [1:0]    state_q, state_d;
  logic [DW-1:0] cap_q, cap_d;
  logic [IW-1:0] idx_q, idx_d;
  logic          busy_q, busy_d;
  logic          valid_q, valid_d;
  logic [3:0]    digit_q, digit_d;
  logic [IW-1:0] index_q, index_d;
  logic          blank_q, blank_d;
  logic          bad_q, bad_d;
  logic          last_q, last_d;
  logic          done_q, done_d;
  logic [3:0]    sel_digit;
  logic          lead_nz;

  // Next state plus output values derived from the next state so every output is a flop.
  always_comb begin
    state_d   = state_q;
    cap_d     = cap_q;
    idx_d     = idx_q;
    sel_digit = 4'd0;
    lead_nz   = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (start_in) begin
          cap_d   = digits_in;
          idx_d   = IW'(DIGITS_NUM - 1);
          state_d = ST_SEND;
        end
      end
      ST_SEND: begin
        // valid_out is always high in SEND, so ready_in alone completes a beat
        if (ready_in) begin
          if (idx_q == '0) state_d = ST_DONE;
          else             idx_d   = idx_q - IW'(1);
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    // A digit is blanked only while every digit at or above it is zero
    for (int unsigned k = 0; k < DIGITS_NUM; k++) begin
      if (IW'(k) == idx_d) sel_digit = cap_d[4*k +: 4];
      if ((k >= 32'(idx_d)) && (cap_d[4*k +: 4] != 4'd0)) lead_nz = 1'b1;
    end

    valid_d = (state_d == ST_SEND);
    busy_d  = (state_d != ST_IDLE);
    done_d  = (state_d == ST_DONE);
    digit_d = valid_d ? sel_digit : 4'd0;
    index_d = valid_d ? idx_d : '0;
    blank_d = valid_d && (idx_d != '0) && !lead_nz;
    bad_d   = valid_d && (sel_digit > 4'd9);
    last_d  = valid_d && (idx_d == '0);
  end

  always_ff @(posedge clk_in or posedge reset_in) begin
    if (reset_in) begin
      state_q <= ST_IDLE;
      cap_q   <= '0;
      idx_q   <= '0;
      busy_q  <= 1'b0;
      valid_q <= 1'b0;
      digit_q <= 4'd0;
      index_q <= '0;
      blank_q <= 1'b0;
      bad_q   <= 1'b0;
      last_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cap_q   <= cap_d;
      idx_q   <= idx_d;
      busy_q  <= busy_d;
      valid_q <= valid_d;
      digit_q <= digit_d;
      index_q <= index_d;
      blank_q <= blank_d;
      bad_q   <= bad_d;
      last_q  <= last_d;
      done_q  <= done_d;
    end
  end

  assign busy_out  = busy_q;
  assign valid_out = valid_q;
  assign digit_out = digit_q;
  assign index_out = index_q;
  assign blank_out = blank_q;
  assign bad_out   = bad_q;
  assign last_out  = last_q;
  assign done_out  = done_q;

endmodule
